// File: rtl/turkey_sensor_driver_if.sv
// Sensor-driver bundle: start/dir/dwell request side plus beam pair, status and sent counters.
// Latency: none, plain wires; the driver registers every output it places on this bundle.
// Backpressure: none; start is a level request honoured only while the driver is idle. TURKEY_BACKOUT_EN adds backout.
interface turkey_sensor_driver_if #(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 8
);
   logic               start;
   logic               dir;
   logic [DWELL_W-1:0] dwell;
`ifdef TURKEY_BACKOUT_EN
   logic               backout;
`endif
   logic               L;
   logic               R;
   logic               busy;
   logic               done;
   logic [CNT_W-1:0]   lr_sent;
   logic [CNT_W-1:0]   rl_sent;

`ifdef TURKEY_BACKOUT_EN
   // Driver side: takes the request, produces beams and status
   modport master (input start, dir, dwell, backout,
                   output L, R, busy, done, lr_sent, rl_sent);
   // Requester / beam consumer side
   modport slave  (output start, dir, dwell, backout,
                   input L, R, busy, done, lr_sent, rl_sent);
`else
   // Driver side: takes the request, produces beams and status
   modport master (input start, dir, dwell,
                   output L, R, busy, done, lr_sent, rl_sent);
   // Requester / beam consumer side
   modport slave  (output start, dir, dwell,
                   input L, R, busy, done, lr_sent, rl_sent);
`endif
endinterface

// File: rtl/turkey_sensor_driver.sv
// Turkey-gate stimulus: plays one crossing on active-low beams L/R (ENTER, BOTH, EXIT, CLEAR).
// Latency: beams show ENTER one cycle after start is sampled in IDLE; crossing = 3*max(dwell,1)+1 cycles.
// Backpressure: start ignored while busy (not queued). TURKEY_BACKOUT_EN adds a retreat sequence, uncounted.
module turkey_sensor_driver #(
   parameter int DWELL_W = 8,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   turkey_sensor_driver_if.master bus
);

   typedef enum logic [2:0] {IDLE, ENTER, BOTH, EXIT, CLEAR} state_t;

   state_t             state_q;
   logic               L_q, R_q, busy_q, done_q;
   logic               dir_q;
   logic               retreat_q;      // second ENTER of a backout sequence
   logic [DWELL_W-1:0] dwell_q;        // effective dwell, never zero
   logic [DWELL_W-1:0] cnt_q;
   logic [CNT_W-1:0]   lr_q, rl_q;

   logic [DWELL_W-1:0] dwell_ld_d;
   logic               phase_end;
   logic               backout_now;

   // dwell = 0 behaves as 1 so every phase is visible for at least one cycle
   assign dwell_ld_d = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
   assign phase_end  = (cnt_q == DWELL_W'(1));

`ifdef TURKEY_BACKOUT_EN
   logic backout_q;

   // Latch the retreat request together with the accepted start
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         backout_q <= 1'b0;
      end else if (state_q == IDLE && bus.start) begin
         backout_q <= bus.backout;
      end
   end

   assign backout_now = backout_q;
`else
   assign backout_now = 1'b0;
`endif

   // Crossing sequencer with registered beams, status and sent counters
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         L_q       <= 1'b1;
         R_q       <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dir_q     <= 1'b0;
         retreat_q <= 1'b0;
         dwell_q   <= '0;
         cnt_q     <= '0;
         lr_q      <= '0;
         rl_q      <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_q   <= ENTER;
                  dir_q     <= bus.dir;
                  dwell_q   <= dwell_ld_d;
                  cnt_q     <= dwell_ld_d;
                  retreat_q <= 1'b0;
                  busy_q    <= 1'b1;
                  // entry side blocked first: left for dir 0, right for dir 1
                  L_q       <= bus.dir;
                  R_q       <= ~bus.dir;
               end
            end
            ENTER: begin
               if (!phase_end) begin
                  cnt_q <= cnt_q - DWELL_W'(1);
               end else if (retreat_q) begin
                  // turkey backed out: finish without counting it
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  L_q     <= 1'b1;
                  R_q     <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= BOTH;
                  cnt_q   <= dwell_q;
                  L_q     <= 1'b0;
                  R_q     <= 1'b0;
               end
            end
            BOTH: begin
               if (!phase_end) begin
                  cnt_q <= cnt_q - DWELL_W'(1);
               end else if (backout_now) begin
                  state_q   <= ENTER;
                  retreat_q <= 1'b1;
                  cnt_q     <= dwell_q;
                  L_q       <= dir_q;
                  R_q       <= ~dir_q;
               end else begin
                  state_q <= EXIT;
                  cnt_q   <= dwell_q;
                  L_q     <= ~dir_q;
                  R_q     <= dir_q;
               end
            end
            EXIT: begin
               if (!phase_end) begin
                  cnt_q <= cnt_q - DWELL_W'(1);
               end else begin
                  state_q <= CLEAR;
                  cnt_q   <= '0;
                  L_q     <= 1'b1;
                  R_q     <= 1'b1;
                  done_q  <= 1'b1;
                  if (dir_q) rl_q <= rl_q + CNT_W'(1);
                  else       lr_q <= lr_q + CNT_W'(1);
               end
            end
            CLEAR: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               L_q     <= 1'b1;
               R_q     <= 1'b1;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.L       = L_q;
   assign bus.R       = R_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.lr_sent = lr_q;
   assign bus.rl_sent = rl_q;

endmodule

// File: tb/tb_turkey_sensor_driver.sv
// Directed bench for turkey_sensor_driver with a reference crossing receiver on L/R.
// Latency: samples every cycle on the falling edge, one cycle after each accepted start.
// Backpressure: exercises ignored starts while busy and held-high start. Honours TURKEY_BACKOUT_EN.
module tb_turkey_sensor_driver;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   // reference receiver state
   logic [1:0] rx_prev = 2'b11;
   logic [1:0] rx_hist [3];
   int         rx_n = 0;
   int         rx_lr = 0;
   int         rx_rl = 0;

   turkey_sensor_driver_if #(.DWELL_W(8), .CNT_W(8)) dut_if ();

   turkey_sensor_driver #(.DWELL_W(8), .CNT_W(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (dut_if.master)
   );

   always #5 clk = ~clk;

   // Receiver: records the distinct non-idle beam patterns and classifies on return to 11
   always @(negedge clk) begin
      logic [1:0] cur;
      cur = {dut_if.L, dut_if.R};
      if (cur != rx_prev) begin
         if (cur == 2'b11) begin
            if (rx_n == 3 && rx_hist[0] == 2'b01 && rx_hist[1] == 2'b00 && rx_hist[2] == 2'b10)
               rx_lr++;
            else if (rx_n == 3 && rx_hist[0] == 2'b10 && rx_hist[1] == 2'b00 && rx_hist[2] == 2'b01)
               rx_rl++;
            rx_n = 0;
         end else if (rx_n < 3) begin
            rx_hist[rx_n] = cur;
            rx_n++;
         end else begin
            rx_n = 4;
         end
         rx_prev = cur;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // One crossing with cycle-by-cycle check of {L,R,busy,done}
   task automatic do_crossing(input logic d, input logic [7:0] dw, input logic bo, input string tag);
      int         de;
      logic [1:0] ent, ext;
      logic [3:0] e [$];
      de  = (dw == 8'd0) ? 1 : int'(dw);
      ent = d ? 2'b10 : 2'b01;
      ext = d ? 2'b01 : 2'b10;
      for (int i = 0; i < de; i++) e.push_back({ent, 2'b10});
      for (int i = 0; i < de; i++) e.push_back({2'b00, 2'b10});
      for (int i = 0; i < de; i++) e.push_back({(bo ? ent : ext), 2'b10});
      e.push_back(4'b1111);
      e.push_back(4'b1100);
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.dir   = d;
      dut_if.dwell = dw;
`ifdef TURKEY_BACKOUT_EN
      dut_if.backout = bo;
`endif
      @(negedge clk);
      // disturb the inputs: latched values must govern the crossing
      dut_if.start = 1'b0;
      dut_if.dir   = ~d;
      dut_if.dwell = 8'd7;
`ifdef TURKEY_BACKOUT_EN
      dut_if.backout = ~bo;
`endif
      for (int i = 0; i < e.size(); i++) begin
         if (i > 0) @(negedge clk);
         if (i == 2) dut_if.start = 1'b1;   // ignored while busy
         if (i == e.size() - 2) dut_if.start = 1'b0;
         chk($sformatf("%s_cyc%0d", tag, i), {28'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done}, {28'd0, e[i]});
      end
   endtask

   initial begin
      int         rx_lr0, rx_rl0, dones;
      logic [3:0] pat [8];
      pat[0] = 4'b0110; pat[1] = 4'b0110; pat[2] = 4'b0010; pat[3] = 4'b0010;
      pat[4] = 4'b1010; pat[5] = 4'b1010; pat[6] = 4'b1111; pat[7] = 4'b1100;

      dut_if.start = 1'b0;
      dut_if.dir   = 1'b0;
      dut_if.dwell = 8'd0;
`ifdef TURKEY_BACKOUT_EN
      dut_if.backout = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("in_reset", {12'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done, dut_if.lr_sent, dut_if.rl_sent},
          {12'd0, 4'b1100, 16'd0});
      reset_n = 1'b1;

      // idle after reset release
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk($sformatf("idle%0d", i), {12'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done, dut_if.lr_sent, dut_if.rl_sent},
             {12'd0, 4'b1100, 16'd0});
      end

      // left-to-right, dwell 3
      do_crossing(1'b0, 8'd3, 1'b0, "lr_d3");
      chk("lr_d3_lr_sent", {24'd0, dut_if.lr_sent}, 32'd1);
      chk("lr_d3_rl_sent", {24'd0, dut_if.rl_sent}, 32'd0);
      chk("lr_d3_rx_lr", rx_lr, 32'd1);
      chk("lr_d3_rx_rl", rx_rl, 32'd0);

      // right-to-left, dwell 0 acts as 1
      do_crossing(1'b1, 8'd0, 1'b0, "rl_d0");
      chk("rl_d0_lr_sent", {24'd0, dut_if.lr_sent}, 32'd1);
      chk("rl_d0_rl_sent", {24'd0, dut_if.rl_sent}, 32'd1);
      chk("rl_d0_rx_rl", rx_rl, 32'd1);

      // asynchronous reset during BOTH
      rx_lr0 = rx_lr;
      rx_rl0 = rx_rl;
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.dir   = 1'b0;
      dut_if.dwell = 8'd3;
      @(negedge clk);
      dut_if.start = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_both_lr", {30'd0, dut_if.L, dut_if.R}, 32'd0);
      #2 reset_n = 1'b0;
      #1 chk("async_rst", {12'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done, dut_if.lr_sent, dut_if.rl_sent},
             {12'd0, 4'b1100, 16'd0});
      @(negedge clk);
      chk("rst_held", {28'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done}, {28'd0, 4'b1100});
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_after", {28'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done}, {28'd0, 4'b1100});
      chk("rst_rx_none", rx_lr + rx_rl, rx_lr0 + rx_rl0);
      do_crossing(1'b0, 8'd1, 1'b0, "clean");
      chk("clean_lr_sent", {24'd0, dut_if.lr_sent}, 32'd1);
      chk("clean_rx_lr", rx_lr, rx_lr0 + 1);

      // held start, dwell 2: back-to-back crossings and counter wrap
      do_reset();
      rx_lr0 = rx_lr;
      dones  = 0;
      @(negedge clk);
      dut_if.start = 1'b1;
      dut_if.dir   = 1'b0;
      dut_if.dwell = 8'd2;
      for (int k = 0; k < 256 * 8; k++) begin
         @(negedge clk);
         if (dut_if.done) dones++;
         if (k < 16)
            chk($sformatf("b2b_cyc%0d", k), {28'd0, dut_if.L, dut_if.R, dut_if.busy, dut_if.done}, {28'd0, pat[k % 8]});
         if (k == 255 * 8 - 1) chk("b2b_lr_255", {24'd0, dut_if.lr_sent}, 32'd255);
      end
      dut_if.start = 1'b0;
      chk("b2b_wrap", {24'd0, dut_if.lr_sent}, 32'd0);
      chk("b2b_dones", dones, 32'd256);
      chk("b2b_rx_lr", rx_lr, rx_lr0 + 256);

`ifdef TURKEY_BACKOUT_EN
      // backout: ENTER, BOTH, ENTER, CLEAR without counting
      rx_lr0 = rx_lr;
      rx_rl0 = rx_rl;
      do_crossing(1'b0, 8'd2, 1'b1, "backout");
      chk("backout_lr_sent", {24'd0, dut_if.lr_sent}, 32'd0);
      chk("backout_rl_sent", {24'd0, dut_if.rl_sent}, 32'd0);
      chk("backout_rx", rx_lr + rx_rl, rx_lr0 + rx_rl0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/turkey_sensor_driver.md
Name: turkey_sensor_driver

Overview:
- Stimulus generator for the two-beam turkey gate: drives the active-low sensor pair (L, R) through the exact waveform of one turkey crossing, left-to-right or right-to-left.
- Acts as the transmitter end of the sensor interface consumed by the crossing-counter FSM.
- Used for board self-test and demo mode.
- Inputs are a start/busy/done handshake, a direction bit and a per-phase dwell time.

Parameters:
- DWELL_W, 8, width of the dwell-time input and internal dwell counter.
- CNT_W, 8, width of the sent-crossing counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request one crossing; sampled only in IDLE.
- dir  input  1  0 = left-to-right, 1 = right-to-left; latched on accepted start.
- dwell  input  DWELL_W  cycles each sensor phase is held; latched on accepted start.
- L  output  1  left beam, registered; 0 = blocked, 1 = clear.
- R  output  1  right beam, registered; 0 = blocked, 1 = clear.
- busy  output  1  high from the cycle after an accepted start until return to IDLE.
- done  output  1  one-cycle pulse when a crossing completes.
- lr_sent  output  CNT_W  completed left-to-right crossings.
- rl_sent  output  CNT_W  completed right-to-left crossings.

Behaviour:
- Reset (async assert, sync release) values: state = IDLE, L = 1, R = 1, busy = 0, done = 0, lr_sent = 0, rl_sent = 0, dwell counter = 0.
- States: IDLE, ENTER, BOTH, EXIT, CLEAR.
- Beam values {L,R} per state:
  - dir = 0: ENTER = {0,1}, BOTH = {0,0}, EXIT = {1,0}.
  - dir = 1: ENTER = {1,0}, BOTH = {0,0}, EXIT = {0,1}.
  - IDLE and CLEAR = {1,1}.
- Start acceptance:
  - start in IDLE is accepted; dir and dwell are latched, and state becomes ENTER on the next edge.
  - Latency: L/R show the ENTER value 1 cycle after the start sample.
  - start outside IDLE is ignored; it is not queued.
- Dwell: each of ENTER, BOTH and EXIT lasts exactly max(dwell_latched, 1) cycles. dwell = 0 is treated as 1. Changing the dwell input mid-crossing has no effect.
- Dwell counter: loads on state entry and decrements each cycle; the state advances on the edge where the count = 1.
- CLEAR:
  - Lasts exactly 1 cycle, with {L,R} = {1,1} and done = 1.
  - On entry to CLEAR, lr_sent (dir = 0) or rl_sent (dir = 1) increments by 1, wrapping modulo 2^CNT_W.
  - CLEAR -> IDLE unconditionally. A start during CLEAR is ignored.
- busy: 1 in ENTER, BOTH, EXIT and CLEAR; 0 in IDLE. A new start is accepted on the first IDLE cycle.
- Full crossing length: ENTER through CLEAR = 3*max(dwell,1) + 1 cycles.
- Outputs are registered and glitch-free; L and R never change in the same cycle except on IDLE/CLEAR transitions defined above.
- Reset mid-crossing: immediately {L,R} = {1,1}, busy = 0, no done, counters cleared.

Optional Feature:
- Macro: TURKEY_BACKOUT_EN.
- With the macro defined:
  - Extra input port backout (1 bit), latched with start.
  - When latched backout = 1, the sequence becomes ENTER, BOTH, ENTER, CLEAR: the turkey retreats to the entry side.
  - Each phase keeps the same dwell.
  - done still pulses in CLEAR, but neither counter increments, since the crossing must not be counted by the receiver.
- Without the macro: the port is absent and every crossing is a full crossing.

Test Plan:
- Reset release, no start for 20 cycles -> L = 1, R = 1, busy = 0, done = 0, counters = 0 throughout.
- start with dir = 0, dwell = 3 -> {L,R} = 01 x3, 00 x3, 10 x3, then 11 with done = 1 for 1 cycle; lr_sent = 1; busy high for 10 cycles; golden crossing-counter FSM fed L/R emits exactly one L_R_count.
- start with dir = 1, dwell = 0 -> {L,R} = 10, 00, 01, 11 one cycle each; rl_sent = 1; receiver emits one R_L_count.
- start held high continuously with dwell = 2 -> back-to-back crossings, one IDLE cycle between them; after 256 crossings lr_sent wraps to 0.
- reset_n pulsed low during BOTH -> L = R = 1 asynchronously; no done; counters = 0; next start runs a clean crossing.
- TURKEY_BACKOUT_EN defined, backout = 1, dir = 0, dwell = 2 -> {L,R} = 01 01 00 00 01 01 11; done pulses; lr_sent unchanged; receiver counts nothing.
